fetch_queue_stage: RTL and testbench

//  Parametrised instruction fetch stage: owns the PC, drives the icache lookup, and buffers fetched
//  {pc, inst} pairs in a circular fetch queue of FQ_DEPTH entries in front of decode.

---
 rtl/fetch_queue_stage_pkg.sv | 33 +++
 rtl/fetch_queue_stage_queue.sv | 74 +++++++
 rtl/fetch_queue_stage.sv | 118 +++++++++++
 tb/tb_fetch_queue_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and constants for the fetch stage.
//   ARCH_LEN / INST_LEN / PHY_LEN : architectural PC, instruction and
//                                   physical icache address widths
//   inst_fetched_t                : head-of-queue view handed to decode
//   fq_entry_t                    : one buffered {pc, inst} pair
package fetch_queue_stage_pkg;

    localparam int unsigned ARCH_LEN = 32;
    localparam int unsigned INST_LEN = 32;
    localparam int unsigned PHY_LEN  = 20;

    localparam logic [31:0] PERF_MAX = '1;

    typedef struct packed {
        logic                valid;
        logic [INST_LEN-1:0] inst;
    } inst_fetched_t;

    typedef struct packed {
        logic [ARCH_LEN-1:0] pc;
        logic [INST_LEN-1:0] inst;
    } fq_entry_t;

    // Redirect targets are word aligned by clearing the two low bits.
    function automatic logic [ARCH_LEN-1:0] align_pc(input logic [ARCH_LEN-1:0] pc);
        return pc & ~ARCH_LEN'(3);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == PERF_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_queue.sv
// fetch_queue: circular FIFO of fq_entry_t placed in front of decode.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : discard all entries (wins over push/pop this cycle)
//   push, wdata  : write wdata at the tail; caller guarantees !full
//   pop          : advance head; ignored when empty
//   head_valid   : queue is non-empty
//   head         : entry at the head pointer
//   count        : occupancy, 0..DEPTH
//   full         : count == DEPTH
module fetch_queue
    import fetch_queue_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fq_entry_t                wdata,
    input  logic                     pop,
    output logic                     head_valid,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fq_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full       = (cnt == FULL_CNT);
        head_valid = (cnt != '0);
        do_push    = push && !full;
        do_pop     = pop && head_valid;
        head       = mem[rd_ptr];
        count      = cnt;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: owns the PC, drives the icache lookup and buffers
// fetched {pc, inst} pairs in a fetch queue ahead of decode.
//   clk, rst          : clock, synchronous active-high reset
//   stall_fet_in      : suppress new fetches (dequeue still allowed)
//   br_tk, pc_br_tk   : redirect: flush queue, load aligned target
//   ic_addr, ic_en    : icache lookup address and enable
//   ic_data, ic_miss  : icache response for the current lookup
//   inst_fetched_out  : queue head {valid, inst}
//   pc_out            : PC of the queue head, 0 when empty
//   dec_ready         : decode consumes the head this cycle
//   fq_count          : queue occupancy
//   perf_*            : saturating event counters, present only when
//                       FETCH_PERF_CNT_EN is defined
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int unsigned         FQ_DEPTH  = 4,
    parameter logic [ARCH_LEN-1:0] BOOT_ADDR = '0,
    parameter int unsigned         PC_STEP   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_fet_in,
    input  logic                      br_tk,
    input  logic [ARCH_LEN-1:0]       pc_br_tk,
    output logic [PHY_LEN-1:0]        ic_addr,
    output logic                      ic_en,
    input  logic [INST_LEN-1:0]       ic_data,
    input  logic                      ic_miss,
    output inst_fetched_t             inst_fetched_out,
    output logic [ARCH_LEN-1:0]       pc_out,
    input  logic                      dec_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]               perf_miss_cyc,
    output logic [31:0]               perf_full_cyc,
    output logic [31:0]               perf_redirects,
`endif
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    logic [ARCH_LEN-1:0]        pc;
    logic                       q_full;
    logic                       q_valid;
    fq_entry_t                  q_head;
    fq_entry_t                  q_wdata;
    logic [$clog2(FQ_DEPTH):0]  q_count;
    logic                       push;
    logic                       pop;

    always_comb begin
        ic_en   = !rst && !br_tk && !stall_fet_in && !q_full;
        ic_addr = pc[PHY_LEN-1:0];
        push    = ic_en && !ic_miss;
        // A redirect discards any head decode might be taking this cycle.
        pop     = q_valid && dec_ready && !br_tk && !rst;
        q_wdata = '{pc: pc, inst: ic_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= BOOT_ADDR;
        end else if (br_tk) begin
            pc <= align_pc(pc_br_tk);
        end else if (push) begin
            pc <= pc + ARCH_LEN'(PC_STEP);
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (br_tk),
        .push       (push),
        .wdata      (q_wdata),
        .pop        (pop),
        .head_valid (q_valid),
        .head       (q_head),
        .count      (q_count),
        .full       (q_full)
    );

    always_comb begin
        inst_fetched_out = '0;
        pc_out           = '0;
        fq_count         = '0;
        if (!rst) begin
            fq_count = q_count;
            if (q_valid) begin
                inst_fetched_out.valid = 1'b1;
                inst_fetched_out.inst  = q_head.inst;
                pc_out                 = q_head.pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_miss_cyc  <= '0;
            perf_full_cyc  <= '0;
            perf_redirects <= '0;
        end else begin
            if (ic_en && ic_miss) begin
                perf_miss_cyc <= sat_inc(perf_miss_cyc);
            end
            if (q_full && !stall_fet_in) begin
                perf_full_cyc <= sat_inc(perf_full_cyc);
            end
            if (br_tk) begin
                perf_redirects <= sat_inc(perf_redirects);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage. The icache model answers every
// lookup with 0xC0000000 | address, so expected instruction words follow
// directly from the PC.
module tb_fetch_queue_stage;
    import fetch_queue_stage_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall_fet_in;
    logic                br_tk;
    logic [ARCH_LEN-1:0] pc_br_tk;
    logic [PHY_LEN-1:0]  ic_addr;
    logic                ic_en;
    logic [INST_LEN-1:0] ic_data;
    logic                ic_miss;
    inst_fetched_t       inst_fetched_out;
    logic [ARCH_LEN-1:0] pc_out;
    logic                dec_ready;
    logic [2:0]          fq_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]         perf_miss_cyc;
    logic [31:0]         perf_full_cyc;
    logic [31:0]         perf_redirects;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign ic_data = 32'hC000_0000 | 32'(ic_addr);

    fetch_queue_stage #(
        .FQ_DEPTH  (4),
        .BOOT_ADDR (32'h0),
        .PC_STEP   (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_fet_in     (stall_fet_in),
        .br_tk            (br_tk),
        .pc_br_tk         (pc_br_tk),
        .ic_addr          (ic_addr),
        .ic_en            (ic_en),
        .ic_data          (ic_data),
        .ic_miss          (ic_miss),
        .inst_fetched_out (inst_fetched_out),
        .pc_out           (pc_out),
        .dec_ready        (dec_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_miss_cyc    (perf_miss_cyc),
        .perf_full_cyc    (perf_full_cyc),
        .perf_redirects   (perf_redirects),
`endif
        .fq_count         (fq_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall_fet_in = 1'b0;
        br_tk        = 1'b0;
        pc_br_tk     = '0;
        ic_miss      = 1'b0;
        dec_ready    = 1'b1;

        // 1: reset, then streaming with decode always ready
        tick();
        check("rst_ic_en", 64'(ic_en), 64'd0);
        check("rst_count", 64'(fq_count), 64'd0);
        check("rst_valid", 64'(inst_fetched_out.valid), 64'd0);
        check("rst_pc_out", 64'(pc_out), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t1_ic_en", 64'(ic_en), 64'd1);
        check("t1_ic_addr", 64'(ic_addr), 64'h0);
        check("t1_empty", 64'(inst_fetched_out.valid), 64'd0);
        tick();
        check("t1_head0_pc", 64'(pc_out), 64'h0);
        check("t1_head0_inst", 64'(inst_fetched_out.inst), 64'hC000_0000);
        check("t1_count", 64'(fq_count), 64'd1);
        tick();
        check("t1_head1_pc", 64'(pc_out), 64'h4);
        tick();
        check("t1_head2_pc", 64'(pc_out), 64'h8);
        check("t1_head2_inst", 64'(inst_fetched_out.inst), 64'hC000_0008);

        // 2: decode back-pressure fills the queue
        rst       = 1'b1;
        dec_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_fill_count", 64'(fq_count), 64'(i));
        end
        check("t2_full_ic_en", 64'(ic_en), 64'd0);
        check("t2_full_ic_addr", 64'(ic_addr), 64'h10);
        check("t2_full_head", 64'(pc_out), 64'h0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        #1;
        check("t2_pop_count", 64'(fq_count), 64'd3);
        check("t2_pop_head", 64'(pc_out), 64'h4);
        check("t2_resume_ic_en", 64'(ic_en), 64'd1);
        check("t2_resume_addr", 64'(ic_addr), 64'h10);
        tick();
        check("t2_refill_count", 64'(fq_count), 64'd4);
        check("t2_refill_ic_en", 64'(ic_en), 64'd0);
        check("t2_refill_addr", 64'(ic_addr), 64'h14);

        // 3: miss at pc 0x8 retried until hit
        rst       = 1'b1;
        dec_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t3_pre_head", 64'(pc_out), 64'h4);
        check("t3_pre_addr", 64'(ic_addr), 64'h8);
        ic_miss   = 1'b1;
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_miss_addr", 64'(ic_addr), 64'h8);
            check("t3_miss_count", 64'(fq_count), 64'd1);
        end
        check("t3_miss_ic_en", 64'(ic_en), 64'd1);
        ic_miss = 1'b0;
        tick();
        check("t3_hit_count", 64'(fq_count), 64'd2);
        check("t3_hit_head", 64'(pc_out), 64'h4);
        stall_fet_in = 1'b1;
        dec_ready    = 1'b1;
        #1;
        check("t3_stall_ic_en", 64'(ic_en), 64'd0);
        tick();
        check("t3_entry_pc", 64'(pc_out), 64'h8);
        check("t3_entry_inst", 64'(inst_fetched_out.inst), 64'hC000_0008);
        check("t3_entry_count", 64'(fq_count), 64'd1);

        // 4: redirect with three entries queued
        stall_fet_in = 1'b0;
        dec_ready    = 1'b0;
        #1;
        check("t4_addr", 64'(ic_addr), 64'hC);
        tick();
        tick();
        check("t4_count3", 64'(fq_count), 64'd3);
        br_tk    = 1'b1;
        pc_br_tk = 32'h103;
        #1;
        check("t4_br_ic_en", 64'(ic_en), 64'd0);
        tick();
        br_tk = 1'b0;
        #1;
        check("t4_flush_count", 64'(fq_count), 64'd0);
        check("t4_flush_valid", 64'(inst_fetched_out.valid), 64'd0);
        check("t4_flush_pc_out", 64'(pc_out), 64'h0);
        check("t4_target_addr", 64'(ic_addr), 64'h100);
        tick();
        check("t4_target_head", 64'(pc_out), 64'h100);
        check("t4_target_inst", 64'(inst_fetched_out.inst), 64'hC000_0100);
        check("t4_target_count", 64'(fq_count), 64'd1);

        // 5: redirect, dec_ready and hit in the same cycle
        br_tk     = 1'b1;
        dec_ready = 1'b1;
        pc_br_tk  = 32'h200;
        tick();
        br_tk     = 1'b0;
        dec_ready = 1'b0;
        #1;
        check("t5_count", 64'(fq_count), 64'd0);
        check("t5_valid", 64'(inst_fetched_out.valid), 64'd0);
        check("t5_addr", 64'(ic_addr), 64'h200);

        // 6: reset while full with a miss pending
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("t6_full_count", 64'(fq_count), 64'd4);
        check("t6_full_head", 64'(pc_out), 64'h200);
        check("t6_full_addr", 64'(ic_addr), 64'h210);
        ic_miss = 1'b1;
        rst     = 1'b1;
        #1;
        check("t6_rst_ic_en", 64'(ic_en), 64'd0);
        check("t6_rst_count", 64'(fq_count), 64'd0);
        check("t6_rst_valid", 64'(inst_fetched_out.valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_post_count", 64'(fq_count), 64'd0);
        check("t6_post_valid", 64'(inst_fetched_out.valid), 64'd0);
        check("t6_post_addr", 64'(ic_addr), 64'h0);
`ifdef FETCH_PERF_CNT_EN
        check("t6_perf_miss", 64'(perf_miss_cyc), 64'd0);
        check("t6_perf_full", 64'(perf_full_cyc), 64'd0);
        check("t6_perf_redir", 64'(perf_redirects), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
